// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR sweep sequencer slice.
package fir_pkg;

   localparam int FIR_ADDR_W  = 8;
   localparam int FIR_MAC_LAT = 2;

   typedef enum logic [2:0] {
      IDLE,
      COEF,
      WRITE,
      RUN,
      DRAIN,
      DONE
   } fir_seq_state_t;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index k and latched tap count Tq for one sweep; exposes the next-cycle
// index and flags so the sequencer can register its outputs one cycle ahead.
module fir_tap_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush_i,
   input  logic       load_i,
   input  logic       inc_i,
   input  logic [7:0] taps_i,
   output logic [7:0] k_next_o,
   output logic       first_next_o,
   output logic       last_next_o,
   output logic       last_o
);

   logic [7:0] k_q, k_d;
   logic [7:0] tq_q, tq_d;

   always_comb begin
      k_d  = k_q;
      tq_d = tq_q;
      if (load_i) begin
         k_d  = '0;
         // A zero tap count still runs a single tap
         tq_d = (taps_i == 8'd0) ? 8'd1 : taps_i;
      end else if (inc_i) begin
         k_d = k_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q  <= '0;
         tq_q <= '0;
      end else if (flush_i) begin
         k_q  <= '0;
         tq_q <= '0;
      end else begin
         k_q  <= k_d;
         tq_q <= tq_d;
      end
   end

   assign k_next_o     = k_d;
   assign first_next_o = (k_d == 8'd0);
   assign last_next_o  = (k_d == tq_d - 8'd1);
   assign last_o       = (k_q == tq_q - 8'd1);

endmodule

// File: rtl/fir_sweep_sequencer.sv
// Sequences buffer write, tap sweep and MAC drain for each sample strobe, and
// grants host coefficient access only between sweeps.
module fir_sweep_sequencer
   import fir_pkg::*;
#(
   parameter int ADDR_W  = FIR_ADDR_W,
   parameter int MAC_LAT = FIR_MAC_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              audio_en,
   input  logic              sample_valid,
   input  logic [7:0]        taps_per_filter,
   input  logic              coef_req,
   output logic              coef_gnt,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [ADDR_W-1:0] buf_rd_addr,
   output logic [ADDR_W-1:0] coef_rd_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              mac_last,
   output logic              result_valid,
   output logic              busy,
   output logic              overrun
);

   fir_seq_state_t    state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic [2:0]        drain_q, drain_d;

   logic              buf_we_q, buf_we_d;
   logic [ADDR_W-1:0] buf_wr_addr_q, buf_wr_addr_d;
   logic [ADDR_W-1:0] buf_rd_addr_q, buf_rd_addr_d;
   logic [ADDR_W-1:0] coef_rd_addr_q, coef_rd_addr_d;
   logic              mac_clr_q, mac_clr_d;
   logic              mac_en_q, mac_en_d;
   logic              mac_last_q, mac_last_d;
   logic              result_valid_q, result_valid_d;

   logic [7:0]        k_next;
   logic              first_next, last_next, tap_last;
   logic              run_next, write_next;

   fir_tap_counter u_tap_counter (
      .clk          (clk),
      .rst          (reset),
      .flush_i      (!audio_en),
      .load_i       (state_q == WRITE),
      .inc_i        (state_q == RUN),
      .taps_i       (taps_per_filter),
      .k_next_o     (k_next),
      .first_next_o (first_next),
      .last_next_o  (last_next),
      .last_o       (tap_last)
   );

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      drain_d   = drain_q;

      // Only one sample may wait behind a busy sequencer; a second is lost
      if (sample_valid && (state_q != IDLE)) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (sample_valid || pending_q) begin
               state_d   = WRITE;
               pending_d = 1'b0;
            end else if (coef_req) begin
               state_d = COEF;
            end
         end
         COEF: begin
            if (!coef_req) begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            state_d  = RUN;
         end
         RUN: begin
            if (tap_last) begin
               drain_d = '0;
               state_d = (MAC_LAT == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (drain_q == 3'(MAC_LAT - 1)) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!audio_en) begin
         state_d   = IDLE;
         wr_ptr_d  = '0;
         pending_d = 1'b0;
         overrun_d = 1'b0;
         drain_d   = '0;
      end
   end

   // Outputs are registered from the next state so they line up with it
   always_comb begin
      run_next   = (state_d == RUN);
      write_next = (state_d == WRITE);

      buf_we_d       = write_next;
      buf_wr_addr_d  = write_next ? (wr_ptr_q + ADDR_W'(1)) : '0;
      buf_rd_addr_d  = run_next ? (wr_ptr_d - ADDR_W'(k_next)) : '0;
      coef_rd_addr_d = run_next ? ADDR_W'(k_next) : '0;
      mac_en_d       = run_next;
      mac_clr_d      = run_next && first_next;
      mac_last_d     = run_next && last_next;
      result_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         pending_q      <= 1'b0;
         overrun_q      <= 1'b0;
         drain_q        <= '0;
         buf_we_q       <= 1'b0;
         buf_wr_addr_q  <= '0;
         buf_rd_addr_q  <= '0;
         coef_rd_addr_q <= '0;
         mac_clr_q      <= 1'b0;
         mac_en_q       <= 1'b0;
         mac_last_q     <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         pending_q      <= pending_d;
         overrun_q      <= overrun_d;
         drain_q        <= drain_d;
         buf_we_q       <= buf_we_d       && audio_en;
         buf_wr_addr_q  <= audio_en ? buf_wr_addr_d  : '0;
         buf_rd_addr_q  <= audio_en ? buf_rd_addr_d  : '0;
         coef_rd_addr_q <= audio_en ? coef_rd_addr_d : '0;
         mac_clr_q      <= mac_clr_d      && audio_en;
         mac_en_q       <= mac_en_d       && audio_en;
         mac_last_q     <= mac_last_d     && audio_en;
         result_valid_q <= result_valid_d && audio_en;
      end
   end

   assign coef_gnt     = (state_q == COEF);
   assign busy         = (state_q != IDLE);
   assign overrun      = overrun_q;
   assign buf_we       = buf_we_q;
   assign buf_wr_addr  = buf_wr_addr_q;
   assign buf_rd_addr  = buf_rd_addr_q;
   assign coef_rd_addr = coef_rd_addr_q;
   assign mac_clr      = mac_clr_q;
   assign mac_en       = mac_en_q;
   assign mac_last     = mac_last_q;
   assign result_valid = result_valid_q;

endmodule
